window_line_buffer: RTL
=======================

// Module: window_line_buffer
// PURPOSE
//  Parametrised single-line pixel buffer feeding a K-wide horizontal sliding window
//  to the convolution datapath. Pixels stream in raster order with valid/ready flow control.
//  Windows are read out one column step at a time. After the last window of a line, the
//  remaining K-1 pixels of that line are released automatically.
// PARAMETERS
//  PIX_W   8    bits per pixel
//  LINE_W  512  pixels per line = storage depth; any value >= K, need not be a power of 2
//  K       3    window width in pixels, 2..LINE_W
// PORTS
//  clk          in   1              rising-edge clock, single clock domain
//  rst          in   1              asynchronous, active-high reset
//  in_pixel     in   PIX_W          write pixel
//  in_valid     in   1              write request
//  in_ready     out  1              space available; write accepted when in_valid && in_ready
//  rd_en        in   1              advance window; accepted only when win_avail
//  win_avail    out  1              occupancy >= K
//  win_valid    out  1              win_data/line_done valid, one cycle after accepted rd_en
//  win_data     out  K*PIX_W        window; oldest pixel (column c) in MSBs, column c+K-1 in LSBs
//  line_done    out  1              qualifies win_valid: this is the last window of the line
//  level        out  $clog2(LINE_W+1)  pixels held
//  err_sticky   out  2              only with LINE_BUF_ERR_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): wr_ptr, rd_ptr, rd_col, level, win_valid, line_done, win_data go to 0.
//    in_ready=1, win_avail=0. Storage is not cleared. A reset mid-line discards the partial line.
//  - in_ready = (level < LINE_W), combinational from the level register.
//  - win_avail = (level >= K), combinational from the level register.
//  - Write: mem[wr_ptr] <= in_pixel. wr_ptr increments modulo LINE_W (explicit wrap
//    LINE_W-1 -> 0, not natural overflow).
//  - Write while full is dropped: no state change.
//  - Read (rd_en && win_avail):
//    - win_data is registered from mem[(rd_ptr+i) mod LINE_W], i=0..K-1. Latency is 1 cycle.
//    - If rd_col < LINE_W-K:
//      - rd_ptr += 1 (mod LINE_W), rd_col += 1, freed = 1, line_done = 0.
//    - If rd_col == LINE_W-K (last window of the line):
//      - rd_ptr += K (mod LINE_W), rd_col = 0, freed = K, line_done = 1.
//  - rd_en without win_avail is ignored. win_valid=0 next cycle.
//  - win_valid is a one-cycle pulse per accepted read. win_data holds its value between reads.
//  - level_next = level + wr_acc - (rd_acc ? freed : 0).
//    - A simultaneous write and read is legal in every state, including level==LINE_W.
//    - In that case in_ready=0, so the write is refused that cycle even though space frees.
//  - The read address of the write-in-progress pixel is never exposed: win_avail uses
//    registered level, so new data is visible one cycle after the write.
//  - All pointer arithmetic is done at width $clog2(LINE_W)+1 before the mod reduction,
//    so the +K step cannot overflow.
// CONFIGURATION
//  `LINE_BUF_ERR_EN` defined:
//    - adds err_sticky[1:0].
//    - bit0 sets on in_valid && !in_ready.
//    - bit1 sets on rd_en && !win_avail.
//    - cleared only by rst.
//  `LINE_BUF_ERR_EN` undefined: port absent; those events are silently dropped as above.
// STRUCTURE
//  - line_buf_pkg: shared constants, functions and typedefs.
//    - Constants: PTR_W = $clog2(LINE_W), LVL_W = $clog2(LINE_W+1).
//    - Function mod_add(ptr, inc, LINE_W) for wrap-safe pointer stepping.
//    - typedef of the pixel type.
//  - Sub-module line_buf_mem holds the register-array storage.
//    - One synchronous write port.
//    - K combinational read taps at base+i mod LINE_W.
//  - Top level holds pointers, rd_col, level, and the output register stage.
// TESTING  (PIX_W=8, LINE_W=8, K=3 unless noted)
//  1 Reset: assert rst asynchronously mid-clock.
//    -> in_ready=1, win_avail=0, level=0, win_valid=0 immediately, without waiting for clk.
//  2 Fill: write 0x10..0x17, then issue rd_en for 6 cycles.
//    -> win_data 0x101112, 0x111213, ... 0x151617.
//    -> line_done only on the 6th window; level 8->7->...->3->0.
//  3 Full/wrap: write 8 pixels; 9th write with in_valid=1.
//    -> in_ready=0, pixel dropped, level=8.
//    -> Next line writes wrap wr_ptr 7->0; windows of line 2 are correct.
//  4 Simultaneous: at level=5, assert in_valid and rd_en for 4 cycles.
//    -> level stays 5; every window is correct.
//  5 Underflow: rd_en with level=2.
//    -> no win_valid, state unchanged.
//    -> with LINE_BUF_ERR_EN, err_sticky=2'b10 held until rst.
//  6 LINE_W=7, K=5: stream 3 lines back-to-back.
//    -> 3 windows per line; rd_ptr +5 wrap is correct; 3 line_done pulses.

Source files
------------

// File: rtl/line_buf_pkg.sv
// line_buf_pkg: shared constants, pixel type and wrap-safe pointer stepping for the window line buffer.
package line_buf_pkg;

    localparam int PIX_W_DEF  = 8;
    localparam int LINE_W_DEF = 512;
    localparam int PTR_W      = $clog2(LINE_W_DEF);
    localparam int LVL_W      = $clog2(LINE_W_DEF + 1);

    typedef logic [PIX_W_DEF-1:0] pix_t;

    // inc never exceeds n and ptr < n, so a single conditional subtract wraps correctly
    function automatic int mod_add(input int ptr, input int inc, input int n);
        return (ptr + inc >= n) ? ptr + inc - n : ptr + inc;
    endfunction

endpackage

// File: rtl/line_buf_mem.sv
// line_buf_mem: register-array line storage with one synchronous write port and K combinational read taps.
module line_buf_mem
    import line_buf_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int K      = 3,
    parameter int AW     = PTR_W
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [PIX_W-1:0]   wdata_i,
    input  logic [AW-1:0]      base_i,
    output logic [K*PIX_W-1:0] taps_o
);

    logic [PIX_W-1:0] mem [LINE_W];

    always_ff @(posedge clk)
        if (we_i) mem[waddr_i] <= wdata_i;

    // tap 0 is the oldest pixel and lands in the MSBs
    for (genvar i = 0; i < K; i++) begin : g_tap
        assign taps_o[(K-i)*PIX_W-1 -: PIX_W] = mem[AW'(mod_add(int'(base_i), i, LINE_W))];
    end

endmodule

// File: rtl/window_line_buffer.sv
// window_line_buffer: single-line pixel buffer producing a K-wide sliding window per read.
// Optional LINE_BUF_ERR_EN adds sticky overflow/underflow flags on err_sticky.
module window_line_buffer
    import line_buf_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int K      = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PIX_W-1:0]            in_pixel,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        rd_en,
    output logic                        win_avail,
    output logic                        win_valid,
    output logic [K*PIX_W-1:0]          win_data,
    output logic                        line_done,
    output logic [$clog2(LINE_W+1)-1:0] level
`ifdef LINE_BUF_ERR_EN
    ,
    output logic [1:0]                  err_sticky
`endif
);

    localparam int AW = $clog2(LINE_W);
    localparam int LW = $clog2(LINE_W + 1);

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_col_q, rd_col_d;
    logic [LW-1:0]      level_q, level_d, freed;
    logic [K*PIX_W-1:0] taps, win_data_q;
    logic               win_valid_q, line_done_q, wr_acc, rd_acc, last;

    assign in_ready  = level_q < LW'(LINE_W);
    assign win_avail = level_q >= LW'(K);
    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign line_done = line_done_q;
    assign level     = level_q;

    line_buf_mem #(.PIX_W(PIX_W), .LINE_W(LINE_W), .K(K), .AW(AW)) u_mem (
        .clk    (clk),
        .we_i   (wr_acc),
        .waddr_i(wr_ptr_q),
        .wdata_i(in_pixel),
        .base_i (rd_ptr_q),
        .taps_o (taps)
    );

    // the last window of a line releases the whole window, otherwise one column slides out
    always_comb begin
        wr_acc   = in_valid && in_ready;
        rd_acc   = rd_en && win_avail;
        last     = rd_col_q == AW'(LINE_W - K);
        freed    = last ? LW'(K) : LW'(1);
        wr_ptr_d = wr_acc ? AW'(mod_add(int'(wr_ptr_q), 1, LINE_W)) : wr_ptr_q;
        rd_ptr_d = rd_acc ? AW'(mod_add(int'(rd_ptr_q), last ? K : 1, LINE_W)) : rd_ptr_q;
        rd_col_d = rd_acc ? (last ? '0 : rd_col_q + AW'(1)) : rd_col_q;
        level_d  = level_q + LW'(wr_acc) - (rd_acc ? freed : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_col_q    <= '0;
            level_q     <= '0;
            win_valid_q <= 1'b0;
            line_done_q <= 1'b0;
            win_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_col_q    <= rd_col_d;
            level_q     <= level_d;
            win_valid_q <= rd_acc;
            line_done_q <= rd_acc && last;
            if (rd_acc) win_data_q <= taps;
        end
    end

`ifdef LINE_BUF_ERR_EN
    logic [1:0] err_q;

    assign err_sticky = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= '0;
        else     err_q <= err_q | {rd_en && !win_avail, in_valid && !in_ready};
    end
`endif

endmodule
